// File: rtl/uart_tx_fifo_gen2.sv
// Transmit FIFO between the bus write logic and the UART TX serialiser.
// First-word-fall-through output, with level flags, sticky errors, flush and an occupancy watermark.
module uart_tx_fifo_gen2 #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       err_clr,
  input  logic                       wm_clr,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     max_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              do_wr;
  logic              do_rd;
  logic              ovf_evt;
  logic              udf_evt;
  logic [CNT_W-1:0]  cnt_nxt;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign data_out     = fifo_empty ? '0 : mem[rd_ptr];

  // A push against a full FIFO is still accepted when a pop frees the head slot on the same edge.
  always_comb begin
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      do_wr   = push && (!fifo_full || pop);
      do_rd   = pop && !fifo_empty;
      ovf_evt = push && fifo_full && !pop;
      udf_evt = pop && fifo_empty;
      cnt_nxt = count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_level <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= cnt_nxt;
      // wm_clr restarts tracking from the post-edge occupancy rather than from zero.
      if (wm_clr || (cnt_nxt > max_level)) begin
        max_level <= cnt_nxt;
      end
      overflow  <= ovf_evt || (overflow  && !err_clr);
      underflow <= udf_evt || (underflow && !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_gen2.sv
// Directed bench for uart_tx_fifo_gen2 at DATA_W=8, DEPTH=16, AFULL_LVL=12, AEMPTY_LVL=2.
module tb_uart_tx_fifo_gen2;

  logic       clk;
  logic       rstn;
  logic       push;
  logic       pop;
  logic       flush;
  logic       err_clr;
  logic       wm_clr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
  logic [4:0] count;
  logic [4:0] max_level;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_head;

  uart_tx_fifo_gen2 #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AFULL_LVL (12),
    .AEMPTY_LVL(2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .err_clr     (err_clr),
    .wm_clr      (wm_clr),
    .data_in     (data_in),
    .data_out    (data_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .count       (count),
    .max_level   (max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of controls, clock it, and leave the outputs settled 1 ns after the edge.
  task automatic step(input logic p, input logic q, input logic f, input logic ec,
                      input logic wc, input logic [7:0] d);
    push    = p;
    pop     = q;
    flush   = f;
    err_clr = ec;
    wm_clr  = wc;
    data_in = d;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    wm_clr  = 1'b0;
    data_in = 8'h00;
  endtask

  initial begin
    rstn = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    err_clr = 1'b0; wm_clr = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_dout", data_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    check("rst_max", max_level, 0);
    rstn = 1'b1;

    // Reset mid-operation, between clock edges
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 8'h30 + 8'(i));
    check("pre_rst_count", count, 5);
    check("pre_rst_dout", data_out, 8'h30);
    #2 rstn = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", fifo_empty, 1);
    check("arst_dout", data_out, 0);
    check("arst_max", max_level, 0);
    #1 rstn = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 0, 8'(i));
      check("fill_count", count, 32'(i + 1));
      check("fill_afull", almost_full, (i + 1) >= 12);
      check("fill_full", fifo_full, (i + 1) == 16);
      check("fill_aempty", almost_empty, (i + 1) <= 2);
    end
    check("fill_max", max_level, 16);
    check("fill_head", data_out, 8'h00);

    // Drain
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", data_out, 32'(i));
      step(0, 1, 0, 0, 0, 8'h00);
      check("drain_count", count, 32'(15 - i));
      check("drain_aempty", almost_empty, (15 - i) <= 2);
      check("drain_empty", fifo_empty, i == 15);
    end
    check("drain_dout_zero", data_out, 0);
    check("drain_max", max_level, 16);
    check("drain_udf", underflow, 0);

    // Overflow
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 8'h10 + 8'(i));
    step(1, 0, 0, 0, 0, 8'hAA);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_head", data_out, 8'h10);
    step(0, 0, 0, 1, 0, 8'h00);
    check("ovf_clr", overflow, 0);
    step(1, 1, 0, 0, 0, 8'hBB);
    check("fullpp_count", count, 16);
    check("fullpp_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain", data_out, (i < 15) ? 32'h11 + 32'(i) : 32'hBB);
      step(0, 1, 0, 0, 0, 8'h00);
    end
    check("ovf_drain_empty", fifo_empty, 1);

    // Underflow, and push+pop on empty
    step(0, 1, 0, 0, 0, 8'h00);
    check("udf_flag", underflow, 1);
    check("udf_count", count, 0);
    step(0, 0, 0, 1, 0, 8'h00);
    check("udf_clr", underflow, 0);
    step(1, 1, 0, 0, 0, 8'h5C);
    check("epp_count", count, 1);
    check("epp_dout", data_out, 8'h5C);
    check("epp_udf", underflow, 1);
    step(0, 1, 0, 1, 0, 8'h00);
    check("epp_drain", fifo_empty, 1);
    check("epp_clr", underflow, 0);

    // Wrap-around with occupancy held 6..7
    step(0, 0, 0, 0, 1, 8'h00);
    check("wm_clr_max", max_level, 0);
    model_q.delete();
    for (int w = 0; w < 7; w++) begin
      step(1, 0, 0, 0, 0, 8'h80 + 8'(w));
      model_q.push_back(8'h80 + 8'(w));
    end
    for (int w = 7; w < 40; w++) begin
      exp_head = model_q.pop_front();
      check("wrap_dout", data_out, exp_head);
      if (w % 3 == 0) begin
        step(0, 1, 0, 0, 0, 8'h00);
        check("wrap_count_lo", count, 6);
        step(1, 0, 0, 0, 0, 8'h80 + 8'(w));
      end else begin
        step(1, 1, 0, 0, 0, 8'h80 + 8'(w));
      end
      model_q.push_back(8'h80 + 8'(w));
      check("wrap_count", count, 7);
    end
    while (model_q.size() > 0) begin
      exp_head = model_q.pop_front();
      check("wrap_tail", data_out, exp_head);
      step(0, 1, 0, 0, 0, 8'h00);
    end
    check("wrap_empty", fifo_empty, 1);
    check("wrap_ovf", overflow, 0);
    check("wrap_udf", underflow, 0);
    check("wrap_max", max_level, 7);

    // Flush priority over push/pop
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 8'h40 + 8'(i));
    check("fl_pre_count", count, 9);
    step(1, 1, 1, 0, 0, 8'hEE);
    check("fl_count", count, 0);
    check("fl_empty", fifo_empty, 1);
    check("fl_dout", data_out, 0);
    check("fl_ovf", overflow, 0);
    check("fl_udf", underflow, 0);
    check("fl_max", max_level, 9);
    step(0, 1, 1, 0, 0, 8'h00);
    check("fl_empty_pop_udf", underflow, 0);
    step(1, 0, 0, 0, 0, 8'h77);
    check("fl_after_dout", data_out, 8'h77);

    // err_clr loses to a new overflow in the same cycle
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, 8'h60 + 8'(i));
    check("ec_full", fifo_full, 1);
    step(1, 0, 0, 1, 0, 8'hAB);
    check("ec_ovf_wins", overflow, 1);
    check("ec_max", max_level, 16);
    step(0, 0, 0, 0, 1, 8'h00);
    check("wm_clr_loads_count", max_level, 16);
    step(0, 1, 0, 0, 1, 8'h00);
    check("wm_clr_next_count", max_level, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
